// File: rtl/reg_arb_defs_pkg.sv
// Shared encodings and default sizing for the register-bank write arbiter.
package reg_arb_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_NREG  = 4;
  localparam int DEF_WIDTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit searching upward from ptr, wrapping at N.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          win_vld
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate index (ptr + i) mod N without a divider.
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
      if (!win_vld && mask[cand]) begin
        win_vld       = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter owning the write port and clear of a load-enable register bank.
// req sampled at edge t -> one-cycle gnt/reg_en, bank loads at t+1; requests wait (level req) until granted, clear has priority.
module reg_bank_arbiter
  import reg_arb_defs_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int NREG  = DEF_NREG,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREG-1:0]       reg_en,
  output logic [WIDTH-1:0]      reg_din,
  output logic                  reg_rst,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_t        state, state_nxt;
  logic [PW-1:0]     ptr;
  logic              clr_pend;
  logic [AW-1:0]     hold_addr;
  logic [WIDTH-1:0]  hold_data;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   win_oh;
  logic [PW-1:0]     win_idx;
  logic              win_vld;

  // The current grantee may still be deasserting during its WRITE cycle.
  assign elig = (state == ST_WRITE) ? (req & ~gnt) : req;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .mask    (elig),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    reg_en    = '0;
    reg_din   = '0;
    reg_rst   = 1'b0;
    busy      = (state != ST_IDLE);
    if ((state != ST_CLEAR) && (clr_pend || clr)) state_nxt = ST_CLEAR;
    else if (win_vld)                             state_nxt = ST_WRITE;
    case (state)
      ST_WRITE: begin
        reg_en[hold_addr] = 1'b1;
        reg_din           = hold_data;
      end
      ST_CLEAR: reg_rst = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      clr_pend  <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
      gnt       <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      if (state_nxt == ST_CLEAR) clr_pend <= 1'b0;
      else if (clr)              clr_pend <= 1'b1;
      if (state_nxt == ST_WRITE) begin
        gnt       <= win_oh;
        hold_addr <= req_addr[win_idx*AW +: AW];
        hold_data <= req_data[win_idx*WIDTH +: WIDTH];
        ptr       <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed literal checks plus randomized requesters against a queue-free behavioural model.
module tb_reg_bank_arbiter;

  localparam int NREQ = 4, NREG = 4, WIDTH = 32, AW = 2;

  logic                  clk = 1'b0;
  logic                  rst, clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREG-1:0]       reg_en;
  logic [WIDTH-1:0]      reg_din;
  logic                  reg_rst, busy;

  int n_vec = 0, n_bad = 0;
  bit chk_en = 0;

  reg_bank_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .clr(clr), .gnt(gnt), .reg_en(reg_en), .reg_din(reg_din),
    .reg_rst(reg_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[k*AW +: AW]       = a;
    req_data[k*WIDTH +: WIDTH] = d;
  endtask

  // Bank as seen through the DUT's outputs.
  logic [WIDTH-1:0] bank [NREG] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++)
      if (reg_en[i]) bank[i] <= reg_din;
    if (reg_rst)
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
  end

  // Behavioural model: mode 0 idle, 1 writing for requester m_k, 2 clearing.
  int               m_state = 0, m_ptr = 0, m_k = 0, m_addr = 0;
  bit               m_pend = 0;
  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] mbank [NREG] = '{default: '0};

  always @(posedge clk) begin : model
    int win, k;
    if (m_state == 1) mbank[m_addr] = m_data;
    if (m_state == 2) for (int i = 0; i < NREG; i++) mbank[i] = '0;
    if (rst) begin
      m_state = 0; m_ptr = 0; m_pend = 0; m_addr = 0; m_data = '0; m_k = 0;
    end else begin
      win = -1;
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (win < 0 && req[k] === 1'b1 && !(m_state == 1 && k == m_k)) win = k;
      end
      if (m_state != 2 && (m_pend || clr === 1'b1)) begin
        m_state = 2; m_pend = 0;
      end else begin
        if (clr === 1'b1) m_pend = 1;
        if (win >= 0) begin
          m_state = 1; m_k = win;
          m_addr  = int'(req_addr[win*AW +: AW]);
          m_data  = req_data[win*WIDTH +: WIDTH];
          m_ptr   = (win + 1) % NREQ;
        end else m_state = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] eg;
    logic [NREG-1:0] ee;
    if (chk_en) begin
      eg = '0; ee = '0;
      if (m_state == 1) begin eg[m_k] = 1'b1; ee[m_addr] = 1'b1; end
      chk("m_gnt", 64'(gnt), 64'(eg));
      chk("m_reg_en", 64'(reg_en), 64'(ee));
      chk("m_reg_din", 64'(reg_din), (m_state == 1) ? 64'(m_data) : 64'd0);
      chk("m_reg_rst", 64'(reg_rst), 64'(m_state == 2));
      chk("m_busy", 64'(busy), 64'(m_state != 0));
    end
  end

  bit active [NREQ];
  int started [NREQ], granted [NREQ], cd [NREQ];
  logic [NREQ-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1; clr = 0; req = '0; req_addr = '0; req_data = '0;
    step(); chk_en = 1; step();
    // Reset then idle
    chk("rst_gnt", 64'(gnt), 0); chk("rst_en", 64'(reg_en), 0);
    chk("rst_rrst", 64'(reg_rst), 0); chk("rst_busy", 64'(busy), 0);
    rst = 0; step();
    chk("idle_busy", 64'(busy), 0);

    // Single write
    set_req(0, 2'd2, 32'd3); req = 4'b0001;
    step();
    chk("wr_gnt", 64'(gnt), 64'b0001); chk("wr_en", 64'(reg_en), 64'b0100);
    chk("wr_din", 64'(reg_din), 3); chk("wr_busy", 64'(busy), 1);
    req = '0; step();
    chk("wr_bank2", 64'(bank[2]), 3); chk("wr_done", 64'(busy), 0);

    // Clear priority, then clear arriving mid-write
    set_req(1, 2'd1, 32'd5); req = 4'b0010; clr = 1;
    step();
    chk("cp_rrst", 64'(reg_rst), 1); chk("cp_gnt", 64'(gnt), 0); chk("cp_en", 64'(reg_en), 0);
    clr = 0; step();
    chk("cp_wgnt", 64'(gnt), 64'b0010); chk("cp_wdin", 64'(reg_din), 5);
    req = '0; clr = 1; step();
    chk("cm_rrst", 64'(reg_rst), 1); chk("cm_bank1", 64'(bank[1]), 5);
    clr = 0; step();
    chk("cm_idle", 64'(busy), 0); chk("cm_bank1_clr", 64'(bank[1]), 0);

    // Reset mid-write; pointer restarts at requester 0
    set_req(2, 2'd0, 32'hdead_beef); req = 4'b0100;
    step();
    chk("rm_en", 64'(reg_en), 64'b0001); chk("rm_gnt", 64'(gnt), 64'b0100);
    rst = 1; req = '0; step();
    chk("rm_en0", 64'(reg_en), 0); chk("rm_gnt0", 64'(gnt), 0); chk("rm_din0", 64'(reg_din), 0);
    rst = 0; step();
    chk("rm_noreissue", 64'(reg_en), 0);
    set_req(1, 2'd3, 32'd11); set_req(3, 2'd1, 32'd22); req = 4'b1010;
    step();
    chk("rm_ptr0", 64'(gnt), 64'b0010); chk("rm_din", 64'(reg_din), 11);
    req = 4'b1000; step();
    chk("b2b_gnt", 64'(gnt), 64'b1000); chk("b2b_en", 64'(reg_en), 64'b0010);
    chk("b2b_din", 64'(reg_din), 22);
    req = '0; step();

    // Round-robin fairness with drop-and-reassert requesters
    for (int k = 0; k < NREQ; k++) begin set_req(k, AW'(k), 32'(100 + k)); cd[k] = 0; end
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_gnt", 64'(gnt), 64'(rr_exp[c]));
      chk("rr_en_active", 64'(reg_en != 0), 1);
      for (int k = 0; k < NREQ; k++) begin
        if (gnt[k]) begin req[k] = 0; cd[k] = 2; end
        else if (cd[k] > 0) begin cd[k]--; if (cd[k] == 0) req[k] = 1; end
      end
    end
    req = '0; step(); step();

    // Randomized requesters obeying the hold-until-gnt contract
    for (int k = 0; k < NREQ; k++) begin active[k] = 0; started[k] = 0; granted[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      clr = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NREQ; k++) begin
        if (gnt[k]) begin active[k] = 0; granted[k]++; req[k] = 0; end
        if (!active[k] && $urandom_range(0, 3) == 0) begin
          set_req(k, AW'($urandom_range(0, NREG-1)), $urandom);
          req[k] = 1; active[k] = 1; started[k]++;
        end
      end
      step();
    end
    clr = 0; rst = 0;
    begin : drain
      int left;
      left = 1;
      for (int c = 0; c < 200 && left != 0; c++) begin
        left = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (gnt[k]) begin active[k] = 0; granted[k]++; req[k] = 0; end
          if (active[k]) left++;
        end
        step();
      end
      chk("drain_timeout", 64'(left), 0);
    end
    step(); step();
    for (int k = 0; k < NREQ; k++) chk($sformatf("served_req%0d", k), 64'(granted[k]), 64'(started[k]));
    for (int i = 0; i < NREG; i++) chk($sformatf("bank%0d", i), 64'(bank[i]), 64'(mbank[i]));

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
